// File: rtl/lfsr_game_pkg.sv
// Shared types and constants for the LFSR guessing-game controller.
// Imported by the controller, its LFSR and the bench.
package lfsr_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] RES_OOR  = 2'b00;
  localparam logic [1:0] RES_LOW  = 2'b01;
  localparam logic [1:0] RES_HIGH = 2'b10;
  localparam logic [1:0] RES_WIN  = 2'b11;

  // x^8+x^6+x^5+x^4+1 as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam int unsigned DEF_MAX_VAL   = 99;
  localparam int unsigned DEF_MAX_TRIES = 7;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_guess_ctrl_if.sv
// Player-side bundle of the guessing-game controller.
// master = player/test side, slave = controller.
interface lfsr_guess_ctrl_if;

  logic       new_game;
  logic [7:0] guess;
  logic       guess_valid;
  logic       busy;
  logic [1:0] result;
  logic       result_valid;
  logic [3:0] tries;
  logic       game_over;
  logic       win;
  logic [7:0] disp_val;

  modport master (
    output new_game,
    output guess,
    output guess_valid,
    input  busy,
    input  result,
    input  result_valid,
    input  tries,
    input  game_over,
    input  win,
    input  disp_val
  );

  modport slave (
    input  new_game,
    input  guess,
    input  guess_valid,
    output busy,
    output result,
    output result_valid,
    output tries,
    output game_over,
    output win,
    output disp_val
  );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, period 255.
// Steps every cycle except while rst is held.
module lfsr8
  import lfsr_game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/lfsr_guess_ctrl.sv
// Guessing-game controller: draws a target from the LFSR,
// scores guesses, counts tries and drives the display value.
module lfsr_guess_ctrl
  import lfsr_game_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned MAX_VAL   = DEF_MAX_VAL,
  parameter int unsigned MAX_TRIES = DEF_MAX_TRIES
) (
  input logic               clk,
  input logic               rst,
  lfsr_guess_ctrl_if.slave  bus
);

  localparam logic [7:0] MAXV = 8'(MAX_VAL);
  localparam logic [3:0] MAXT = 4'(MAX_TRIES);

  logic [7:0] lfsr_val;

  state_e     state_q,  state_d;
  logic [7:0] target_q, target_d;
  logic [7:0] guess_q,  guess_d;
  logic [1:0] result_q, result_d;
  logic       rvalid_q, rvalid_d;
  logic [3:0] tries_q,  tries_d;
  logic       win_q,    win_d;

  logic [3:0] tries_inc;
  logic       lfsr_ok;
  logic       guess_oor;

  lfsr8 #(
    .SEED   (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr_val)
  );

  assign tries_inc = (tries_q == MAXT) ? tries_q
                                       : tries_q + 4'd1;
  assign lfsr_ok   = (lfsr_val != 8'd0) && (lfsr_val <= MAXV);
  assign guess_oor = (guess_q == 8'd0) || (guess_q > MAXV);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    guess_d  = guess_q;
    result_d = result_q;
    rvalid_d = 1'b0;
    tries_d  = tries_q;
    win_d    = win_q;

    if (bus.new_game) begin
      state_d  = DRAW;
      guess_d  = 8'd0;
      result_d = RES_OOR;
      tries_d  = 4'd0;
      win_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        DRAW: begin
          if (lfsr_ok) begin
            target_d = lfsr_val;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          if (bus.guess_valid) begin
            guess_d = bus.guess;
            state_d = CHECK;
          end
        end
        CHECK: begin
          rvalid_d = 1'b1;
          if (guess_oor) begin
            result_d = RES_OOR;
            state_d  = PLAY;
          end else begin
            tries_d = tries_inc;
            state_d = (tries_inc == MAXT) ? DONE : PLAY;
            unique case (1'b1)
              (guess_q < target_q): result_d = RES_LOW;
              (guess_q > target_q): result_d = RES_HIGH;
              (guess_q == target_q): begin
                result_d = RES_WIN;
                win_d    = 1'b1;
                state_d  = DONE;
              end
              default: ;
            endcase
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= 8'd0;
      guess_q  <= 8'd0;
      result_q <= RES_OOR;
      rvalid_q <= 1'b0;
      tries_q  <= 4'd0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      tries_q  <= tries_d;
      win_q    <= win_d;
    end
  end

  assign bus.busy         = (state_q == DRAW) ||
                            (state_q == CHECK);
  assign bus.game_over    = (state_q == DONE);
  assign bus.disp_val     = (state_q == DONE) ? target_q
                                              : guess_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rvalid_q;
  assign bus.tries        = tries_q;
  assign bus.win          = win_q;

endmodule

// File: tb/tb_lfsr_guess_ctrl.sv
// Directed scoreboard bench for lfsr_guess_ctrl.
// Results are queued at guess time and popped on result_valid.
module tb_lfsr_guess_ctrl;
  import lfsr_game_pkg::*;

  typedef struct {
    logic [1:0] res;
    logic [3:0] tries;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] m;
  logic [7:0] tgt;
  logic [3:0] mtries;
  logic       mwin;
  logic       mdone;

  lfsr_guess_ctrl_if bus ();

  lfsr_guess_ctrl #(
    .LFSR_SEED (8'hA5),
    .MAX_VAL   (99),
    .MAX_TRIES (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mnext(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk) m <= rst ? 8'hA5 : mnext(m);

  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.result, bus.result_valid,
                bus.tries, bus.game_over, bus.win,
                bus.disp_val});
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(bus.result), 32'(mon_e.res));
        chk("res_tries", 32'(bus.tries), 32'(mon_e.tries));
        chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic start_game(input bit with_guess);
    logic [7:0] t;
    int k;
    int cnt;
    t = m;
    k = 0;
    do begin
      t = mnext(t);
      k++;
    end while (!(t >= 8'd1 && t <= 8'd99));
    bus.new_game = 1'b1;
    if (with_guess) begin
      bus.guess       = 8'd50;
      bus.guess_valid = 1'b1;
    end
    @(negedge clk);
    bus.new_game    = 1'b0;
    bus.guess_valid = 1'b0;
    chk("draw_busy", 32'(bus.busy), 32'd1);
    chk("draw_state", 32'(dut.state_q), 32'(DRAW));
    chk("draw_tries", 32'(bus.tries), 32'd0);
    chk("draw_go", 32'(bus.game_over), 32'd0);
    chk("draw_disp", 32'(bus.disp_val), 32'd0);
    cnt = 1;
    while (bus.busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("draw_len", cnt, k + 1);
    chk("play_state", 32'(dut.state_q), 32'(PLAY));
    chk("target", 32'(dut.target_q), 32'(t));
    tgt    = t;
    mtries = 4'd0;
    mwin   = 1'b0;
    mdone  = 1'b0;
  endtask

  task automatic do_guess(input logic [7:0] g);
    exp_t e;
    if (g == 8'd0 || g > 8'd99) begin
      e.res = RES_OOR;
    end else begin
      mtries = mtries + 4'd1;
      if (g < tgt)      e.res = RES_LOW;
      else if (g > tgt) e.res = RES_HIGH;
      else begin
        e.res = RES_WIN;
        mwin  = 1'b1;
      end
      if (mwin || mtries == 4'd7) mdone = 1'b1;
    end
    e.tries = mtries;
    e.cyc   = cyc + 2;
    sb.push_back(e);
    bus.guess       = g;
    bus.guess_valid = 1'b1;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    chk("check_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_go", 32'(bus.game_over), 32'(mdone));
    chk("post_win", 32'(bus.win), 32'(mwin));
    chk("post_tries", 32'(bus.tries), 32'(mtries));
    chk("post_disp", 32'(bus.disp_val),
        32'(mdone ? tgt : g));
    chk("post_state", 32'(dut.state_q),
        32'(mdone ? DONE : PLAY));
  endtask

  initial begin
    logic [7:0] first;
    logic [7:0] wrong;
    int period;
    rst             = 1'b1;
    bus.new_game    = 1'b0;
    bus.guess       = 8'd0;
    bus.guess_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_outs", outs(), 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(IDLE));
    chk("reset_lfsr", 32'(dut.lfsr_val), 32'hA5);
    chk("reset_target", 32'(dut.target_q), 32'd0);

    first  = dut.lfsr_val;
    period = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      chk("idle_outs", outs(), 32'd0);
      chk("idle_lfsr", 32'(dut.lfsr_val), 32'(m));
      chk("lfsr_nonzero", 32'(dut.lfsr_val != 8'd0), 32'd1);
      if (period == 0 && dut.lfsr_val == first) period = i;
    end
    chk("lfsr_period", period, 255);

    // Game 1: below, above, then the target
    start_game(1'b0);
    do_guess(tgt - 8'd1);
    do_guess(tgt + 8'd1);
    do_guess(tgt);
    chk("win_disp", 32'(bus.disp_val), 32'(tgt));

    // Game 2: out-of-range guesses, then seven misses
    start_game(1'b0);
    do_guess(8'd0);
    do_guess(8'd150);
    chk("oor_tries", 32'(bus.tries), 32'd0);
    wrong = (tgt == 8'd99) ? 8'd1 : tgt + 8'd1;
    for (int i = 0; i < 7; i++) do_guess(wrong);
    chk("lose_go", 32'(bus.game_over), 32'd1);
    chk("lose_win", 32'(bus.win), 32'd0);
    chk("lose_tries", 32'(bus.tries), 32'd7);
    chk("lose_disp", 32'(bus.disp_val), 32'(tgt));
    bus.guess       = wrong;
    bus.guess_valid = 1'b1;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("done_hold", 32'(dut.state_q), 32'(DONE));
    chk("done_tries", 32'(bus.tries), 32'd7);

    // Game 3, then new_game colliding with guess_valid
    start_game(1'b0);
    start_game(1'b1);
    chk("collide_rv", 32'(bus.result_valid), 32'd0);

    // Reset during CHECK
    bus.guess       = tgt;
    bus.guess_valid = 1'b1;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    chk("pre_rst_state", 32'(dut.state_q), 32'(CHECK));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outs", outs(), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_lfsr", 32'(dut.lfsr_val), 32'hA5);
    repeat (3) @(negedge clk);
    chk("post_rst_outs", outs(), 32'd0);
    chk("post_rst_lfsr", 32'(dut.lfsr_val), 32'(m));

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
